sram_arbiter_rr: RTL and testbench
==================================

Name: sram_arbiter_rr

Overview:
Parametrised single-clock successor to the SRAM arbiter. It arbitrates NUM_W write ports and NUM_R read ports onto one SRAM command interface using fair round-robin that skips idle ports. It tracks outstanding reads with an in-order tag FIFO and steers returned data into per-read-port return buffers that have ready/valid output handshakes. It sits between the image/overlay producers and consumers and the SRAM controller, with all ports in the SRAM clock domain.

Parameters:
NUM_W, 2, number of write ports
NUM_R, 2, number of read ports
ADDR_W, 18, SRAM word address width
DATA_W, 32, data width
MASK_W, 4, byte write-mask width (DATA_W/8)
TAG_DEPTH, 8, max outstanding reads in flight (power of 2)
RDQ_DEPTH, 4, return-buffer depth per read port (power of 2)

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-high reset
w_din_valid  in  NUM_W  write request valid, one bit per port
w_din  in  NUM_W*(MASK_W+ADDR_W+DATA_W)  per port {mask,addr,data}; port i in slice i
w_din_ready  out  NUM_W  write accepted this cycle
r_din_valid  in  NUM_R  read request valid
r_din  in  NUM_R*ADDR_W  read address per port
r_din_ready  out  NUM_R  read request accepted this cycle
r_dout_valid  out  NUM_R  return data available
r_dout  out  NUM_R*DATA_W  return data per port
r_dout_ready  in  NUM_R  consumer pops return data
sram_addr_valid  out  1  command valid
sram_ready  in  1  SRAM accepts command
sram_addr  out  ADDR_W  command address
sram_data_in  out  DATA_W  write data
sram_write_mask  out  MASK_W  nonzero means write; 0 means read
sram_data_out  in  DATA_W  read data
sram_data_out_valid  in  1  read data strobe, in issue order
err_orphan  out  1  sticky: read data arrived with no outstanding tag

Behaviour:
- Reset: all outputs 0, RR pointer set to W0, tag FIFO, return buffers and credit counters emptied, err_orphan cleared. Reset mid-operation discards in-flight commands and reads.
- Requester order for RR: W0..W(NUM_W-1), then R0..R(NUM_R-1).
- Command register (CR): loads when it is empty or when sram_addr_valid && sram_ready is true this cycle.
- CR hold: while sram_ready=0, CR contents are held stable and no grant is issued.
- Grant selection: when CR can load, grant the first eligible requester at or after the pointer, wrapping around. Exactly one ready bit is asserted, combinationally, in the grant cycle. The pointer moves to granted+1 mod (NUM_W+NUM_R). With no grant, the pointer holds.
- Eligibility: a write port is eligible when its valid is high. A read port j is eligible when its valid is high, the tag FIFO is not full, and credit[j] < RDQ_DEPTH.
- Grant latency: the command appears on the SRAM outputs on the clock edge after the grant, i.e. 1 cycle.
- Read command encoding: mask=0, data_in=0. A write with mask 0 is forwarded unchanged; the SRAM treats it as a read, so producers must not issue it.
- Read issue: pushes port index j into the tag FIFO and increments credit[j].
- Read return: on sram_data_out_valid, pop the tag and push data into return buffer[tag]. Credit guarantees this buffer has room.
- Orphan data: sram_data_out_valid with an empty tag FIFO drops the data and sets err_orphan, which stays set until reset.
- Return buffer output: show-ahead. r_dout_valid[j] = buffer j non-empty; r_dout shows the head entry. A pop on valid&&ready decrements credit[j].
- Simultaneous events: a push and pop on the same buffer in one cycle is legal even when full. A credit increment and decrement in the same cycle leave credit unchanged. Tag push and pop in the same cycle is legal even when full.
- Flow control: r_dout_ready low indefinitely stalls only port j once its credit is exhausted; other ports keep arbitrating.

Test Plan:
- All four ports (2W/2R) request continuously, with W0={F,0,0}, W1={F,1,1}, R0 addr 3, R1 addr 4 and sram_ready=1. Required: commands in order W0,W1,R0,R1,W0,... at 1 per cycle. R0 and R1 commands carry mask 0. The ready pulse matches each grant.
- Only W1 and R1 request. Required: W0/R0 are skipped with no idle slots, giving an alternating W1,R1 command stream.
- Return data 1,2,3,4 strobed after the R0,R1,R0,R1 issue, with r_dout_ready=0. Required: R0 shows 1 and R1 shows 2, both valid. Raising ready gives R0=3 and R1=4 on the next cycle, then both valid=0 on the following cycle.
- R0 with r_dout_ready=0, RDQ_DEPTH=4, and data returned for each read. Required: after 4 R0 grants r_din_ready[0] stays 0 while W0 is still granted. One pop re-enables exactly one more R0 grant.
- sram_ready is held 0 for 3 cycles mid-stream. Required: sram_addr, mask and data are held stable, no din_ready is asserted, and the stream resumes in the correct RR order.
- Two cases: (a) sram_data_out_valid with no reads outstanding, then (b) reset asserted between issue and return. Required: (a) sets err_orphan=1, and subsequent return-buffer contents are unaffected. (b) clears all outputs asynchronously, and stale data after reset is flagged as orphan.

Source files
------------

// File: rtl/sram_arbiter_rr_if.sv
// Request/return handshakes and SRAM command bus of the round-robin SRAM arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface sram_arbiter_rr_if #(
  parameter int NUM_W  = 2,
  parameter int NUM_R  = 2,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
);
  localparam int WW = MASK_W + ADDR_W + DATA_W;

  logic [NUM_W-1:0]        w_din_valid;
  logic [NUM_W*WW-1:0]     w_din;
  logic [NUM_W-1:0]        w_din_ready;
  logic [NUM_R-1:0]        r_din_valid;
  logic [NUM_R*ADDR_W-1:0] r_din;
  logic [NUM_R-1:0]        r_din_ready;
  logic [NUM_R-1:0]        r_dout_valid;
  logic [NUM_R*DATA_W-1:0] r_dout;
  logic [NUM_R-1:0]        r_dout_ready;
  logic                    sram_addr_valid;
  logic                    sram_ready;
  logic [ADDR_W-1:0]       sram_addr;
  logic [DATA_W-1:0]       sram_data_in;
  logic [MASK_W-1:0]       sram_write_mask;
  logic [DATA_W-1:0]       sram_data_out;
  logic                    sram_data_out_valid;
  logic                    err_orphan;

  modport slave (
    input  w_din_valid, w_din, r_din_valid, r_din, r_dout_ready,
           sram_ready, sram_data_out, sram_data_out_valid,
    output w_din_ready, r_din_ready, r_dout_valid, r_dout,
           sram_addr_valid, sram_addr, sram_data_in, sram_write_mask, err_orphan
  );

  modport master (
    output w_din_valid, w_din, r_din_valid, r_din, r_dout_ready,
           sram_ready, sram_data_out, sram_data_out_valid,
    input  w_din_ready, r_din_ready, r_dout_valid, r_dout,
           sram_addr_valid, sram_addr, sram_data_in, sram_write_mask, err_orphan
  );
endinterface

// File: rtl/sram_arbiter_rr.sv
// Round-robin arbiter of NUM_W write and NUM_R read ports onto one SRAM command port,
// with an in-order read tag FIFO and credit-protected per-read-port return buffers.
module sram_arbiter_rr #(
  parameter int NUM_W     = 2,
  parameter int NUM_R     = 2,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32,
  parameter int MASK_W    = 4,
  parameter int TAG_DEPTH = 8,
  parameter int RDQ_DEPTH = 4
) (
  input logic              clock,
  input logic              reset,
  sram_arbiter_rr_if.slave bus
);
  localparam int NUM = NUM_W + NUM_R;
  localparam int WW  = MASK_W + ADDR_W + DATA_W;
  localparam int PW  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int TW  = (NUM_R > 1) ? $clog2(NUM_R) : 1;
  localparam int TAW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int QAW = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
  localparam int TCW = $clog2(TAG_DEPTH + 1);
  localparam int CW  = $clog2(RDQ_DEPTH + 1);

  logic [PW-1:0]     ptr;
  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [MASK_W-1:0] cmd_mask;
  logic              orphan_flag;

  logic [TW-1:0]     tag_mem [TAG_DEPTH];
  logic [TAW-1:0]    tag_wr, tag_rd;
  logic [TCW-1:0]    tag_cnt;

  logic [CW-1:0]     credit  [NUM_R];
  logic [DATA_W-1:0] rdq_mem [NUM_R][RDQ_DEPTH];
  logic [QAW-1:0]    rdq_wr  [NUM_R];
  logic [QAW-1:0]    rdq_rd  [NUM_R];
  logic [CW-1:0]     rdq_cnt [NUM_R];

  logic              cr_load, any_grant, grant_is_read, tag_full, tag_pop, orphan;
  logic [NUM-1:0]    eligible, grant;
  logic [PW-1:0]     grant_idx;
  logic [TW-1:0]     tag_head, issue_port;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [MASK_W-1:0] sel_mask;
  logic [NUM_R-1:0]  rd_issue, rd_push, rd_pop, dout_valid;
  logic [NUM_R*DATA_W-1:0] dout;

  // The command register may take a new command when empty or when its current one is accepted.
  assign cr_load       = !reset && (!cmd_valid || bus.sram_ready);
  assign tag_full      = (tag_cnt == TCW'(TAG_DEPTH));
  assign tag_pop       = bus.sram_data_out_valid && (tag_cnt != '0);
  assign orphan        = bus.sram_data_out_valid && (tag_cnt == '0);
  assign tag_head      = tag_mem[tag_rd];
  assign grant_is_read = any_grant && (int'(grant_idx) >= NUM_W);

  // Requester eligibility: reads also need a free tag slot and return-buffer credit.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_W; i++) eligible[i] = bus.w_din_valid[i];
    for (int j = 0; j < NUM_R; j++)
      eligible[NUM_W+j] = bus.r_din_valid[j] && !tag_full && (credit[j] < CW'(RDQ_DEPTH));
  end

  // First eligible requester at or after the pointer, wrapping around.
  always_comb begin
    int  idx;
    logic hit;
    idx       = 0;
    hit       = 1'b0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      idx       = (int'(ptr) + k >= NUM) ? int'(ptr) + k - NUM : int'(ptr) + k;
      hit       = cr_load && !any_grant && eligible[idx];
      grant_idx = hit ? PW'(idx) : grant_idx;
      any_grant = any_grant || hit;
    end
    grant = any_grant ? (NUM'(1) << grant_idx) : '0;
  end

  // Command fields of the granted requester; reads carry mask 0 and data 0.
  always_comb begin
    sel_mask   = '0;
    sel_addr   = '0;
    sel_data   = '0;
    issue_port = '0;
    for (int i = 0; i < NUM_W; i++)
      {sel_mask, sel_addr, sel_data} = grant[i] ? bus.w_din[i*WW +: WW] : {sel_mask, sel_addr, sel_data};
    for (int j = 0; j < NUM_R; j++) begin
      sel_addr   = grant[NUM_W+j] ? bus.r_din[j*ADDR_W +: ADDR_W] : sel_addr;
      issue_port = grant[NUM_W+j] ? TW'(j) : issue_port;
    end
  end

  // Per-read-port issue, return-push and consumer-pop strobes plus show-ahead outputs.
  always_comb begin
    rd_issue   = '0;
    rd_push    = '0;
    rd_pop     = '0;
    dout_valid = '0;
    dout       = '0;
    for (int j = 0; j < NUM_R; j++) begin
      rd_issue[j] = grant[NUM_W+j];
      rd_push[j]  = tag_pop && (tag_head == TW'(j));
      rd_pop[j]   = (rdq_cnt[j] != '0) && bus.r_dout_ready[j];
      dout_valid[j] = (rdq_cnt[j] != '0);
      dout[j*DATA_W +: DATA_W] = (rdq_cnt[j] != '0) ? rdq_mem[j][rdq_rd[j]] : '0;
    end
  end

  // Command register, round-robin pointer and sticky orphan flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      cmd_mask    <= '0;
      orphan_flag <= 1'b0;
    end else begin
      if (cr_load) begin
        cmd_valid <= any_grant;
        cmd_addr  <= sel_addr;
        cmd_data  <= sel_data;
        cmd_mask  <= sel_mask;
      end
      if (any_grant) ptr <= (int'(grant_idx) == NUM - 1) ? '0 : grant_idx + 1'b1;
      if (orphan) orphan_flag <= 1'b1;
    end
  end

  // Tag FIFO and return-buffer pointers/counters; credit counts tags plus buffered words.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_wr  <= '0;
      tag_rd  <= '0;
      tag_cnt <= '0;
      for (int j = 0; j < NUM_R; j++) begin
        credit[j]  <= '0;
        rdq_wr[j]  <= '0;
        rdq_rd[j]  <= '0;
        rdq_cnt[j] <= '0;
      end
    end else begin
      if (grant_is_read) tag_wr <= tag_wr + 1'b1;
      if (tag_pop) tag_rd <= tag_rd + 1'b1;
      tag_cnt <= tag_cnt + TCW'(grant_is_read) - TCW'(tag_pop);
      for (int j = 0; j < NUM_R; j++) begin
        credit[j]  <= credit[j] + CW'(rd_issue[j]) - CW'(rd_pop[j]);
        rdq_cnt[j] <= rdq_cnt[j] + CW'(rd_push[j]) - CW'(rd_pop[j]);
        if (rd_push[j]) rdq_wr[j] <= rdq_wr[j] + 1'b1;
        if (rd_pop[j]) rdq_rd[j] <= rdq_rd[j] + 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; their contents are only visible through valid counters.
  always_ff @(posedge clock) begin
    if (grant_is_read) tag_mem[tag_wr] <= issue_port;
    for (int j = 0; j < NUM_R; j++)
      if (rd_push[j]) rdq_mem[j][rdq_wr[j]] <= bus.sram_data_out;
  end

  assign bus.w_din_ready     = grant[NUM_W-1:0];
  assign bus.r_din_ready     = grant[NUM-1:NUM_W];
  assign bus.r_dout_valid    = dout_valid;
  assign bus.r_dout          = dout;
  assign bus.sram_addr_valid = cmd_valid;
  assign bus.sram_addr       = cmd_addr;
  assign bus.sram_data_in    = cmd_data;
  assign bus.sram_write_mask = cmd_mask;
  assign bus.err_orphan      = orphan_flag;
endmodule

// File: tb/tb_sram_arbiter_rr.sv
// Self-checking bench for sram_arbiter_rr: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sram_arbiter_rr;
  localparam int NUM_W = 2, NUM_R = 2, ADDR_W = 18, DATA_W = 32, MASK_W = 4;
  localparam int TAG_DEPTH = 8, RDQ_DEPTH = 4;
  localparam int NUM = NUM_W + NUM_R;
  localparam int WW  = MASK_W + ADDR_W + DATA_W;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram_arbiter_rr_if #(.NUM_W(NUM_W), .NUM_R(NUM_R), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .MASK_W(MASK_W)) bus ();

  sram_arbiter_rr #(.NUM_W(NUM_W), .NUM_R(NUM_R), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                    .MASK_W(MASK_W), .TAG_DEPTH(TAG_DEPTH), .RDQ_DEPTH(RDQ_DEPTH))
    dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int issued = 0;    // reads accepted by the SRAM (model side)
  int returned = 0;  // read data strobes driven by the bench

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_ptr;
  bit          m_cmd_valid;
  logic [17:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_mask;
  bit          m_err;
  int          tagq [$];
  logic [31:0] retq [NUM_R][$];

  function automatic int model_credit(int j);
    int n;
    n = retq[j].size();
    foreach (tagq[t]) if (tagq[t] == j) n++;
    return n;
  endfunction

  function automatic bit model_elig(int idx);
    if (idx < NUM_W) return bus.w_din_valid[idx];
    return bus.r_din_valid[idx-NUM_W] && (tagq.size() < TAG_DEPTH) &&
           (model_credit(idx - NUM_W) < RDQ_DEPTH);
  endfunction

  always @(negedge clock) begin : model_proc
    int   g;
    int   t;
    bit   can_load;
    bit   pop [NUM_R];
    logic [3:0] exp_rdy;
    if (reset) begin
      m_ptr = 0; m_cmd_valid = 1'b0; m_err = 1'b0; issued = 0;
      tagq.delete();
      for (int j = 0; j < NUM_R; j++) retq[j].delete();
      check("reset_cmd", {bus.sram_addr_valid, bus.sram_write_mask, bus.sram_addr}, 64'd0);
      check("reset_wdata", bus.sram_data_in, 64'd0);
      check("reset_rdout", bus.r_dout, 64'd0);
      check("reset_flags", {bus.err_orphan, bus.r_dout_valid, bus.r_din_ready, bus.w_din_ready}, 64'd0);
    end else begin
      can_load = !m_cmd_valid || bus.sram_ready;
      g = -1;
      if (can_load)
        for (int k = 0; k < NUM; k++)
          if (g < 0 && model_elig((m_ptr + k) % NUM)) g = (m_ptr + k) % NUM;
      exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      check("ready", {bus.r_din_ready, bus.w_din_ready}, exp_rdy);
      check("cmd_valid", bus.sram_addr_valid, m_cmd_valid);
      if (m_cmd_valid)
        check("cmd", {bus.sram_write_mask, bus.sram_addr, bus.sram_data_in}, {m_mask, m_addr, m_data});
      for (int j = 0; j < NUM_R; j++) begin
        check("rdout_valid", bus.r_dout_valid[j], retq[j].size() > 0);
        if (retq[j].size() > 0) check("rdout_data", bus.r_dout[j*DATA_W +: DATA_W], retq[j][0]);
      end
      check("err_orphan", bus.err_orphan, m_err);
      // advance to the state seen after this clock edge
      if (m_cmd_valid && bus.sram_ready && m_mask == 4'd0) issued++;
      for (int j = 0; j < NUM_R; j++) pop[j] = (retq[j].size() > 0) && bus.r_dout_ready[j];
      for (int j = 0; j < NUM_R; j++) if (pop[j]) void'(retq[j].pop_front());
      if (bus.sram_data_out_valid) begin
        if (tagq.size() > 0) begin
          t = tagq.pop_front();
          retq[t].push_back(bus.sram_data_out);
        end else begin
          m_err = 1'b1;
        end
      end
      if (can_load) begin
        m_cmd_valid = (g >= 0);
        if (g >= 0) begin
          if (g < NUM_W) begin
            {m_mask, m_addr, m_data} = bus.w_din[g*WW +: WW];
          end else begin
            m_mask = 4'd0; m_data = 32'd0;
            m_addr = bus.r_din[(g-NUM_W)*ADDR_W +: ADDR_W];
            tagq.push_back(g - NUM_W);
          end
          m_ptr = (g + 1) % NUM;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.w_din_valid = 2'b00; bus.r_din_valid = 2'b00;
    bus.w_din = '0; bus.r_din = '0; bus.r_dout_ready = 2'b00;
    bus.sram_ready = 1'b1; bus.sram_data_out_valid = 1'b0; bus.sram_data_out = 32'd0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; returned = 0;
    idle_inputs();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clock); #1;
  endtask

  task automatic sample_point();
    @(negedge clock); #1;
  endtask

  task automatic drive_return(input bit random_gap);
    if (issued > returned && (!random_gap || $urandom_range(0, 2) != 0)) begin
      bus.sram_data_out_valid = 1'b1;
      bus.sram_data_out = 32'd100 + 32'(returned);
      returned++;
    end else begin
      bus.sram_data_out_valid = 1'b0;
    end
  endtask

  logic [17:0] rr_addr  [4] = '{18'd0, 18'd1, 18'd3, 18'd4};
  logic [3:0]  rr_mask  [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
  logic [3:0]  hold_rdy [8] = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0001};
  logic [17:0] hold_adr [8] = '{18'd0, 18'd0, 18'd1, 18'd1, 18'd1, 18'd1, 18'd3, 18'd4};
  logic        hold_srd [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic four_port_setup();
    bus.w_din = {4'hF, 18'd1, 32'd1, 4'hF, 18'd0, 32'd0};
    bus.r_din = {18'd4, 18'd3};
  endtask

  initial begin : main
    int r0_grants;
    idle_inputs();

    // All four ports request: W0,W1,R0,R1 at one per cycle, then return 1..4 to R0,R1,R0,R1.
    do_reset();
    four_port_setup();
    bus.w_din_valid = 2'b11; bus.r_din_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      sample_point();
      check("rr4_ready", {bus.r_din_ready, bus.w_din_ready}, 4'b0001 << (k % 4));
      if (k > 0) begin
        check("rr4_addr", bus.sram_addr, rr_addr[(k-1)%4]);
        check("rr4_mask", bus.sram_write_mask, rr_mask[(k-1)%4]);
      end
      next_cycle();
    end
    bus.w_din_valid = 2'b00; bus.r_din_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      bus.sram_data_out_valid = 1'b1; bus.sram_data_out = 32'(k + 1);
      sample_point();
      if (k == 0) check("rr4_last_cmd", {bus.sram_write_mask, bus.sram_addr}, {4'h0, 18'd4});
      next_cycle();
    end
    bus.sram_data_out_valid = 1'b0;
    sample_point();
    check("ret_valid_both", bus.r_dout_valid, 2'b11);
    check("ret_r0_first", bus.r_dout[31:0], 32'd1);
    check("ret_r1_first", bus.r_dout[63:32], 32'd2);
    next_cycle();
    bus.r_dout_ready = 2'b11;
    next_cycle();
    sample_point();
    check("ret_r0_second", bus.r_dout[31:0], 32'd3);
    check("ret_r1_second", bus.r_dout[63:32], 32'd4);
    check("ret_valid_second", bus.r_dout_valid, 2'b11);
    next_cycle();
    sample_point();
    check("ret_drained", bus.r_dout_valid, 2'b00);

    // Only W1 and R1 request: idle ports skipped, alternating stream.
    do_reset();
    four_port_setup();
    bus.r_dout_ready = 2'b11;
    bus.w_din_valid = 2'b10; bus.r_din_valid = 2'b10;
    for (int k = 0; k < 6; k++) begin
      sample_point();
      check("skip_ready", {bus.r_din_ready, bus.w_din_ready}, (k % 2 == 0) ? 4'b0010 : 4'b1000);
      if (k > 0) check("skip_addr", bus.sram_addr, (k % 2 == 1) ? 18'd1 : 18'd4);
      next_cycle();
    end

    // Credit exhaustion on R0 while W0 keeps being granted.
    do_reset();
    bus.w_din = {4'hF, 18'd1, 32'd1, 4'hF, 18'd0, 32'd0};
    bus.r_din = {18'd4, 18'd3};
    bus.w_din_valid = 2'b01; bus.r_din_valid = 2'b01;
    r0_grants = 0;
    for (int k = 0; k < 14; k++) begin
      drive_return(1'b0);
      sample_point();
      if (bus.r_din_ready[0]) r0_grants++;
      if (k >= 10) begin
        check("credit_r0_blocked", bus.r_din_ready[0], 1'b0);
        check("credit_w0_granted", bus.w_din_ready[0], 1'b1);
      end
      next_cycle();
    end
    check("credit_r0_grants", 64'(r0_grants), 64'd4);
    check("credit_head", bus.r_dout[31:0], 32'd100);
    r0_grants = 0;
    for (int k = 0; k < 9; k++) begin
      bus.r_dout_ready = (k == 0) ? 2'b01 : 2'b00;
      drive_return(1'b0);
      sample_point();
      if (bus.r_din_ready[0]) r0_grants++;
      next_cycle();
    end
    check("credit_one_more", 64'(r0_grants), 64'd1);
    check("credit_head_after_pop", bus.r_dout[31:0], 32'd101);

    // sram_ready low for three cycles while W1 is on the bus.
    do_reset();
    four_port_setup();
    bus.r_dout_ready = 2'b11;
    bus.w_din_valid = 2'b11; bus.r_din_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      bus.sram_ready = hold_srd[k];
      sample_point();
      check("hold_ready", {bus.r_din_ready, bus.w_din_ready}, hold_rdy[k]);
      if (k > 0) check("hold_addr", bus.sram_addr, hold_adr[k]);
      if (k >= 2 && k <= 4) check("hold_wcmd", {bus.sram_write_mask, bus.sram_data_in}, {4'hF, 32'd1});
      next_cycle();
    end

    // Orphan data with nothing outstanding, then a normal read.
    do_reset();
    bus.sram_data_out_valid = 1'b1; bus.sram_data_out = 32'hDEAD;
    next_cycle();
    bus.sram_data_out_valid = 1'b0;
    sample_point();
    check("orphan_set", bus.err_orphan, 1'b1);
    check("orphan_no_data", bus.r_dout_valid, 2'b00);
    next_cycle();
    bus.r_din = {18'd0, 18'd7}; bus.r_din_valid = 2'b01;
    next_cycle();
    bus.r_din_valid = 2'b00;
    next_cycle();
    bus.sram_data_out_valid = 1'b1; bus.sram_data_out = 32'h55;
    next_cycle();
    bus.sram_data_out_valid = 1'b0;
    sample_point();
    check("orphan_after_read", {bus.err_orphan, bus.r_dout_valid}, 3'b101);
    check("orphan_after_data", bus.r_dout[31:0], 32'h55);

    // Reset between issue and return: async clear, then stale data is an orphan.
    next_cycle();
    bus.r_din_valid = 2'b01;
    next_cycle();
    bus.r_din_valid = 2'b00;
    sample_point();
    check("mid_issue_cmd", {bus.sram_addr_valid, bus.sram_addr}, {1'b1, 18'd7});
    next_cycle();
    bus.r_din_valid = 2'b01;
    #2 reset = 1'b1;
    #1;
    check("async_cmd", {bus.sram_addr_valid, bus.sram_write_mask, bus.sram_addr}, 64'd0);
    check("async_flags", {bus.err_orphan, bus.r_dout_valid, bus.r_din_ready, bus.w_din_ready}, 64'd0);
    next_cycle();
    reset = 1'b0; bus.r_din_valid = 2'b00; returned = 0;
    bus.sram_data_out_valid = 1'b1; bus.sram_data_out = 32'hBAD;
    next_cycle();
    bus.sram_data_out_valid = 1'b0;
    sample_point();
    check("stale_orphan", {bus.err_orphan, bus.r_dout_valid}, 3'b100);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.w_din_valid = 2'($urandom_range(0, 3));
      bus.r_din_valid = 2'($urandom_range(0, 3));
      for (int i = 0; i < NUM_W; i++)
        bus.w_din[i*WW +: WW] = {4'($urandom_range(1, 15)), 18'($urandom), 32'($urandom)};
      bus.r_din = {18'($urandom), 18'($urandom)};
      bus.sram_ready = ($urandom_range(0, 9) < 7);
      bus.r_dout_ready = 2'($urandom_range(0, 3));
      drive_return(1'b1);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
